cla_word_sequencer: RTL and testbench
=====================================

Name: cla_word_sequencer

Overview:
Multi-cycle controller that performs NUM_BYTES-wide add/subtract by time-multiplexing one external combinational 8-bit carry-lookahead adder slice, one byte per cycle, LSB first. A carry register links the byte steps. Operand requests arrive on a valid/ready handshake, and results leave on a second valid/ready handshake. The block sits between the ALU issue logic and the shared 8-bit adder.

Parameters:
NUM_BYTES, 4, operand width in bytes (>=2); W = 8*NUM_BYTES.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
valid_i  in  1  request valid
ready_o  out  1  request accepted when valid_i & ready_o
a_i  in  W  operand A
b_i  in  W  operand B
c_i  in  1  carry-in (add mode only)
sub_i  in  1  1 = compute A - B
add_a_o  out  8  byte to adder input a
add_b_o  out  8  byte to adder input b
add_c_o  out  1  adder carry-in
add_sum_i  in  8  adder sum (combinational)
add_c_i  in  1  adder carry-out (combinational)
valid_o  out  1  result valid
ready_i  in  1  result consumed when valid_o & ready_i
sum_o  out  W  result
c_o  out  1  final carry-out (for subtract: 1 = no borrow)
ovf_o  out  1  signed overflow
zero_o  out  1  sum_o == 0

Behaviour:
- Reset (async, rst_i=1): state=IDLE, ready_o=1, valid_o=0, sum_o=0, c_o=0, ovf_o=0, zero_o=0, add_*_o=0, byte index=0, carry reg=0. Reset mid-RUN or mid-DONE aborts the operation; no partial result is ever presented.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready_o=1, valid_o=0.
  - On valid_i & ready_o, latch A=a_i and B'= sub_i ? ~b_i : b_i.
  - carry reg <= sub_i ? 1 : c_i (c_i is ignored in subtract mode).
  - idx <= 0; go to RUN.
- RUN:
  - ready_o=0. valid_i is ignored and not queued.
  - Each cycle, combinationally drive add_a_o=A[8*idx+:8], add_b_o=B'[8*idx+:8], add_c_o=carry reg.
  - On the clock edge: result[8*idx+:8] <= add_sum_i; carry reg <= add_c_i; idx <= idx+1.
  - When idx==NUM_BYTES-1, capture the final byte, then:
    - c_o <= add_c_i;
    - ovf_o <= (A[W-1]==B'[W-1]) & (add_sum_i[7]!=A[W-1]);
    - zero_o <= (full result incl. final byte == 0);
    - go to DONE.
- Outside RUN, add_a_o, add_b_o and add_c_o are all 0.
- DONE:
  - valid_o=1. sum_o, c_o, ovf_o and zero_o are held stable.
  - Stays in DONE until ready_i=1, then goes to IDLE on that edge.
  - No same-cycle new acceptance: ready_o is 0 in DONE.
- Latency: request accepted at edge T; adder used in cycles T..T+NUM_BYTES-1; valid_o=1 from edge T+NUM_BYTES. Throughput is 1 op per NUM_BYTES+2 cycles with ready_i tied high.
- sum_o, c_o, ovf_o and zero_o hold the last result while in IDLE and RUN; they are updated only at the RUN→DONE edge.
- Arithmetic is modulo 2^W. Byte index counter width is clog2(NUM_BYTES) and never wraps beyond NUM_BYTES-1.

Test Plan:
- Add, NUM_BYTES=4: A=0x12345678, B=0x0FEDCBA9, c_i=0, sub_i=0 -> sum_o=0x22222221, c_o=0, ovf_o=0, zero_o=0. valid_o rises exactly 4 edges after acceptance. Per-cycle add_a_o sequence 0x78,0x56,0x34,0x12, with add_c_o 0,1,1,1.
- Full carry ripple: A=0xFFFFFFFF, B=0x00000001, c_i=0 -> sum_o=0x00000000, c_o=1, zero_o=1, ovf_o=0. Repeat with c_i=1 and B=0 -> same result.
- Subtract: A=0x00000005, B=0x00000007, sub_i=1, c_i=1 (ignored) -> sum_o=0xFFFFFFFE, c_o=0, ovf_o=0. Then A=7, B=5 -> sum_o=0x00000002, c_o=1.
- Signed overflow: 0x7FFFFFFF+0x00000001 -> 0x80000000, ovf_o=1. Subtract 0x80000000-0x00000001 -> 0x7FFFFFFF, ovf_o=1, c_o=1.
- Backpressure: hold ready_i=0 for 5 cycles in DONE -> valid_o stays 1 and outputs are stable; pulsing valid_i with new operands during RUN and DONE is ignored (ready_o=0). ready_i=1 -> IDLE next edge, and a following request is processed normally.
- Reset mid-operation: assert rst_i asynchronously after the 2nd RUN byte -> all outputs drop to reset values immediately without waiting for a clock. After release, a new add 0x00000001+0x00000001 yields 0x00000002 with no residue from the aborted op.

Source files
------------

// File: rtl/cla_word_sequencer_if.sv
// Request/result handshakes plus the shared 8-bit adder slice port for cla_word_sequencer.
interface cla_word_sequencer_if #(
  parameter int unsigned NUM_BYTES = 4
);
  localparam int unsigned W = 8 * NUM_BYTES;

  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         c_i;
  logic         sub_i;
  logic [7:0]   add_a_o;
  logic [7:0]   add_b_o;
  logic         add_c_o;
  logic [7:0]   add_sum_i;
  logic         add_c_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] sum_o;
  logic         c_o;
  logic         ovf_o;
  logic         zero_o;

  // Sequencer side
  modport slave (
    input  valid_i, a_i, b_i, c_i, sub_i, add_sum_i, add_c_i, ready_i,
    output ready_o, add_a_o, add_b_o, add_c_o, valid_o, sum_o, c_o, ovf_o, zero_o
  );

  // Issue logic / adder / consumer side
  modport master (
    output valid_i, a_i, b_i, c_i, sub_i, add_sum_i, add_c_i, ready_i,
    input  ready_o, add_a_o, add_b_o, add_c_o, valid_o, sum_o, c_o, ovf_o, zero_o
  );
endinterface

// File: rtl/cla_word_sequencer.sv
// Word-wide add/subtract built by stepping one shared 8-bit adder slice LSB-first.
module cla_word_sequencer #(
  parameter int unsigned NUM_BYTES = 4
) (
  input logic                  clk_i,
  input logic                  rst_i,
  cla_word_sequencer_if.slave  bus
);
  localparam int unsigned W     = 8 * NUM_BYTES;
  localparam int unsigned IDX_W = $clog2(NUM_BYTES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, b_q, res_q, res_d;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W+2:0]   bit_base;
  logic               accept, last;
  logic [W-1:0]       sum_q;
  logic               c_q, ovf_q, zero_q, ready_q, valid_q;
  logic [7:0]         add_a_c, add_b_c;
  logic               add_cin_c;

  assign bit_base = {idx_q, 3'b000};

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and byte-step selection
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    res_d   = res_q;
    res_d[bit_base +: 8] = bus.add_sum_i;
    case (state_q)
      IDLE: begin
        accept = bus.valid_i & ready_q;
        if (accept) state_d = RUN;
      end
      RUN: begin
        last = (idx_q == IDX_W'(NUM_BYTES - 1));
        if (last) state_d = DONE;
      end
      DONE: begin
        if (bus.ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Adder slice operands: current byte while running, zero otherwise
  always_comb begin
    add_a_c   = 8'h00;
    add_b_c   = 8'h00;
    add_cin_c = 1'b0;
    if (state_q == RUN) begin
      add_a_c   = a_q[bit_base +: 8];
      add_b_c   = b_q[bit_base +: 8];
      add_cin_c = carry_q;
    end
  end

  // Operand latch, byte accumulation and carry chain
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      a_q     <= bus.a_i;
      b_q     <= bus.sub_i ? ~bus.b_i : bus.b_i;
      res_q   <= '0;
      carry_q <= bus.sub_i ? 1'b1 : bus.c_i;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      res_q   <= res_d;
      carry_q <= bus.add_c_i;
      idx_q   <= last ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Result/flag registers, updated only on the final byte step
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q  <= '0;
      c_q    <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (last) begin
      sum_q  <= res_d;
      c_q    <= bus.add_c_i;
      ovf_q  <= (a_q[W-1] == b_q[W-1]) & (bus.add_sum_i[7] != a_q[W-1]);
      zero_q <= (res_d == '0);
    end
  end

  // Handshake flags registered from the next state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      ready_q <= (state_d == IDLE);
      valid_q <= (state_d == DONE);
    end
  end

  assign bus.ready_o = ready_q;
  assign bus.valid_o = valid_q;
  assign bus.sum_o   = sum_q;
  assign bus.c_o     = c_q;
  assign bus.ovf_o   = ovf_q;
  assign bus.zero_o  = zero_q;
  assign bus.add_a_o = add_a_c;
  assign bus.add_b_o = add_b_c;
  assign bus.add_c_o = add_cin_c;
endmodule

// File: tb/tb_cla_word_sequencer.sv
// Directed bench for cla_word_sequencer with a behavioural 8-bit adder slice.
module tb_cla_word_sequencer;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  logic [7:0] seq_a [4];
  logic       seq_c [4];

  cla_word_sequencer_if #(.NUM_BYTES(4)) bus ();

  cla_word_sequencer #(.NUM_BYTES(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // External combinational adder slice
  assign {bus.add_c_i, bus.add_sum_i} = 9'(bus.add_a_o) + 9'(bus.add_b_o) + 9'(bus.add_c_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One operation; hold = DONE cycles with ready_i low, junk = pulse valid_i during RUN/DONE
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic sub, input logic [31:0] exp_sum,
                        input logic exp_c, input logic exp_ovf, input logic exp_zero,
                        input int hold, input bit junk);
    int k;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.c_i     = c;
    bus.sub_i   = sub;
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b1;
    check({tag, ".ready_idle"}, 64'(bus.ready_o), 64'd1);
    @(posedge clk); #1;
    if (junk) begin
      bus.a_i   = 32'hDEADBEEF;
      bus.b_i   = 32'h0BADF00D;
      bus.sub_i = ~sub;
    end else begin
      bus.valid_i = 1'b0;
    end
    for (k = 0; k < 12; k++) begin
      if (bus.valid_o) break;
      if (k < 4) begin
        seq_a[k] = bus.add_a_o;
        seq_c[k] = bus.add_c_o;
      end
      if (junk) check({tag, ".ready_run"}, 64'(bus.ready_o), 64'd0);
      @(posedge clk); #1;
    end
    check({tag, ".latency"}, 64'(k), 64'd4);
    check({tag, ".sum"},  64'(bus.sum_o),  64'(exp_sum));
    check({tag, ".c"},    64'(bus.c_o),    64'(exp_c));
    check({tag, ".ovf"},  64'(bus.ovf_o),  64'(exp_ovf));
    check({tag, ".zero"}, 64'(bus.zero_o), 64'(exp_zero));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, 64'(bus.valid_o), 64'd1);
      check({tag, ".hold_ready"}, 64'(bus.ready_o), 64'd0);
      check({tag, ".hold_sum"},   64'(bus.sum_o),   64'(exp_sum));
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    bus.ready_i = 1'b0;
    check({tag, ".valid_drop"}, 64'(bus.valid_o), 64'd0);
    check({tag, ".ready_back"}, 64'(bus.ready_o), 64'd1);
    check({tag, ".sum_held"},   64'(bus.sum_o),   64'(exp_sum));
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst         = 1'b1;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    bus.c_i     = 1'b0;
    bus.sub_i   = 1'b0;
    #1;
    check("rst.ready", 64'(bus.ready_o), 64'd1);
    check("rst.valid", 64'(bus.valid_o), 64'd0);
    check("rst.sum",   64'(bus.sum_o),   64'd0);
    check("rst.add_a", 64'(bus.add_a_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("add", 32'h12345678, 32'h0FEDCBA9, 1'b0, 1'b0, 32'h22222221, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    check("add.a0", 64'(seq_a[0]), 64'h78);
    check("add.a1", 64'(seq_a[1]), 64'h56);
    check("add.a2", 64'(seq_a[2]), 64'h34);
    check("add.a3", 64'(seq_a[3]), 64'h12);
    check("add.c0", 64'(seq_c[0]), 64'd0);
    check("add.c1", 64'(seq_c[1]), 64'd1);
    check("add.c2", 64'(seq_c[2]), 64'd1);
    check("add.c3", 64'(seq_c[3]), 64'd1);

    run_op("ripple",  32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    run_op("ripple_cin", 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    run_op("sub5_7",  32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_op("sub7_5",  32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run_op("ovf_add", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    run_op("ovf_sub", 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    run_op("bp",      32'h00001000, 32'h00000234, 1'b1, 1'b0, 32'h00001235, 1'b0, 1'b0, 1'b0, 5, 1'b1);
    run_op("after_bp", 32'hA5A5A5A5, 32'h01010101, 1'b0, 1'b0, 32'hA6A6A6A6, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Abort mid-run with an asynchronous reset pulse
    bus.a_i     = 32'hAAAAAAAA;
    bus.b_i     = 32'h11111111;
    bus.c_i     = 1'b0;
    bus.sub_i   = 1'b0;
    bus.valid_i = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    check("abort.running", 64'(bus.add_a_o), 64'hAA);
    rst = 1'b1;
    #1;
    check("abort.valid", 64'(bus.valid_o), 64'd0);
    check("abort.ready", 64'(bus.ready_o), 64'd1);
    check("abort.sum",   64'(bus.sum_o),   64'd0);
    check("abort.c",     64'(bus.c_o),     64'd0);
    check("abort.ovf",   64'(bus.ovf_o),   64'd0);
    check("abort.zero",  64'(bus.zero_o),  64'd0);
    check("abort.add_a", 64'(bus.add_a_o), 64'd0);
    check("abort.add_b", 64'(bus.add_b_o), 64'd0);
    check("abort.add_c", 64'(bus.add_c_o), 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op("post_rst", 32'h00000001, 32'h00000001, 1'b0, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
